// File: rtl/instr_fetch_stage.sv
// Fetch stage: issues PC-ordered requests to a 1-cycle instruction memory, buffers responses
// in a small circular FIFO and hands {instr, pc} to decode over a valid/ready handshake.
module instr_fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            dec_ready,
  output logic            valid_d,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [6:0]      Op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  localparam int unsigned     PtrW     = $clog2(DEPTH);
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [CntW-1:0] CntFull  = CntW'(DEPTH);
  localparam logic [CntW:0]   OccLimit = (CntW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            rst_q;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic            pop;
  logic            pop_en;
  logic            push;
  logic [CntW:0]   occupancy;

  // Occupancy counts the in-flight slot so a response always has a free entry to land in.
  always_comb begin
    valid_d   = (count_q != '0);
    pop       = valid_d && dec_ready;
    pop_en    = pop && !branch_taken;
    push      = imem_rvalid && inflight_q && !branch_taken;
    occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
    imem_req  = !rst && !rst_q && !branch_taken && (occupancy < OccLimit);
    imem_addr = pc_q;
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rptr_d        = rptr_q;
    wptr_d        = wptr_q;
    count_d       = count_q;
    if (branch_taken) begin
      // Redirect flushes the buffer; the response arriving now is stale and never pushed.
      pc_d    = branch_target;
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (imem_req) begin
        pc_d          = pc_q + XLEN'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (pop_en) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      case ({push, pop_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      rptr_q        <= '0;
      wptr_q        <= '0;
      count_q       <= '0;
      rst_q         <= 1'b1;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      count_q       <= count_d;
      rst_q         <= 1'b0;
    end
  end

  // Storage needs no reset: the head is masked to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem[wptr_q] <= imem_rdata;
      pc_mem[wptr_q]    <= inflight_pc_q;
    end
  end

  always_comb begin
    InstrD   = valid_d ? instr_mem[rptr_q] : '0;
    PCD      = valid_d ? pc_mem[rptr_q] : '0;
    PCPlus4D = PCD + XLEN'(4);
    Op       = InstrD[6:0];
    funct3   = InstrD[14:12];
    funct7   = InstrD[31:25];
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && count_q == CntFull))
    else $error("instr_fetch_stage: push into a full instruction buffer");

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: 1-cycle memory responder, scoreboard of issued fetches,
// and one task per scenario with inline checks.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        dec_ready;
  logic        valid_d;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got_pc[$];
  exp_t        mon_e;
  exp_t        mon_new;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .dec_ready    (dec_ready),
    .valid_d      (valid_d),
    .InstrD       (InstrD),
    .PCD          (PCD),
    .PCPlus4D     (PCPlus4D),
    .Op           (Op),
    .funct3       (funct3),
    .funct7       (funct7)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h00F0_0193;
      32'h0000_0200: return 32'h40B5_0533;
      default:       return {a[29:2], 4'h3};
    endcase
  endfunction

  // Instruction memory: every request answered exactly one cycle later.
  always @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= imem_word(imem_addr);
  end

  // Scoreboard: compare on each accepted pop, then flush on redirect/reset or log new request.
  always @(negedge clk) begin
    if (!rst && !branch_taken && valid_d && dec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_spurious: got PCD=%h InstrD=%h, want no delivery", PCD, InstrD);
      end else begin
        mon_e = exp_q.pop_front();
        if (PCD !== mon_e.pc || InstrD !== mon_e.instr || PCPlus4D !== mon_e.pc + 32'd4 ||
            Op !== mon_e.instr[6:0] || funct3 !== mon_e.instr[14:12] ||
            funct7 !== mon_e.instr[31:25]) begin
          errors++;
          $display("FAIL sb_entry: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h",
                   PCD, InstrD, PCPlus4D, mon_e.pc, mon_e.instr, mon_e.pc + 32'd4);
        end
      end
      got_pc.push_back(PCD);
    end
    if (rst || branch_taken) begin
      exp_q.delete();
    end else if (imem_req) begin
      mon_new.pc    = imem_addr;
      mon_new.instr = imem_word(imem_addr);
      exp_q.push_back(mon_new);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    branch_taken = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    dec_ready     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (valid_d !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl: got valid_d=%b imem_req=%b, want 0 0", valid_d, imem_req);
      end
      checks++;
      if (InstrD !== 32'h0 || PCD !== 32'h0) begin
        errors++;
        $display("FAIL reset_head: got InstrD=%h PCD=%h, want 0 0", InstrD, PCD);
      end
    end
  endtask

  task automatic test_fetch_start();
    int n;
    cyc();
    rst       = 1'b0;
    dec_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      cyc();
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL start_timeout: got imem_req=%b, want 1", imem_req);
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        cyc();
        @(negedge clk);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL start_addr: got req=%b addr=%h, want 1 %h", imem_req, imem_addr, 4 * k);
      end
      checks++;
      if (valid_d !== (k == 2)) begin
        errors++;
        $display("FAIL start_latency: got valid_d=%b at cycle %0d, want %b", valid_d, k, k == 2);
      end
    end
    checks++;
    if (InstrD !== 32'h0050_0093 || PCD !== 32'h0 || Op !== 7'h13 || funct3 !== 3'h0) begin
      errors++;
      $display("FAIL start_head: got InstrD=%h PCD=%h Op=%h f3=%h, want 00500093 0 13 0",
               InstrD, PCD, Op, funct3);
    end
  endtask

  task automatic test_stall();
    int n;
    dec_ready = 1'b0;
    do_reset();
    @(negedge clk);
    n = 0;
    while (valid_d !== 1'b1 && n < 10) begin
      cyc();
      @(negedge clk);
      n++;
    end
    checks++;
    if (valid_d !== 1'b1) begin
      errors++;
      $display("FAIL stall_timeout: got valid_d=%b, want 1", valid_d);
      return;
    end
    got_pc.delete();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        cyc();
        @(negedge clk);
      end
      checks++;
      if (valid_d !== 1'b1 || PCD !== 32'h0 || InstrD !== 32'h0050_0093 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b PCD=%h InstrD=%h req=%b, want 1 0 00500093 0",
                 valid_d, PCD, InstrD, imem_req);
      end
    end
    cyc();
    dec_ready = 1'b1;
    n = 0;
    while (got_pc.size() < 3 && n < 12) begin
      cyc();
      n++;
    end
    checks++;
    if (got_pc.size() != 3 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 ||
        got_pc[2] !== 32'h8) begin
      errors++;
      $display("FAIL stall_order: got %0d entries first=%h, want 3 entries 0,4,8",
               got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx);
    end
  endtask

  task automatic test_redirect();
    cyc();
    cyc();
    dec_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    dec_ready = 1'b1;
    cyc();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    got_pc.delete();
    @(negedge clk);
    checks++;
    if (valid_d !== 1'b1 || imem_req !== 1'b0 || imem_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL redir_cycle: got valid=%b req=%b rvalid=%b, want 1 0 1",
               valid_d, imem_req, imem_rvalid);
    end
    cyc();
    branch_taken = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL redir_next: got valid=%b req=%b addr=%h, want 0 1 00000100",
               valid_d, imem_req, imem_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (valid_d !== 1'b0) begin
      errors++;
      $display("FAIL redir_gap: got valid_d=%b, want 0", valid_d);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (valid_d !== 1'b1 || PCD !== 32'h100 || InstrD !== imem_word(32'h100)) begin
      errors++;
      $display("FAIL redir_first: got valid=%b PCD=%h InstrD=%h, want 1 00000100 %h",
               valid_d, PCD, InstrD, imem_word(32'h100));
    end
    cyc();
    cyc();
    checks++;
    if (got_pc.size() < 2 || got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104) begin
      errors++;
      $display("FAIL redir_stream: got %0d entries, want 0x100 then 0x104", got_pc.size());
    end
  endtask

  task automatic test_reset_with_branch();
    int n;
    cyc();
    rst           = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0300;
    cyc();
    rst          = 1'b0;
    branch_taken = 1'b0;
    got_pc.delete();
    @(negedge clk);
    checks++;
    if (valid_d !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rstbr_next: got valid=%b req=%b, want 0 0", valid_d, imem_req);
    end
    n = 0;
    while (imem_req !== 1'b1 && n < 6) begin
      cyc();
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstbr_pc: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    n = 0;
    while (got_pc.size() < 1 && n < 8) begin
      cyc();
      n++;
    end
    checks++;
    if (got_pc.size() < 1 || got_pc[0] !== 32'h0) begin
      errors++;
      $display("FAIL rstbr_first: got %0d entries, want first PCD 00000000", got_pc.size());
    end
  endtask

  task automatic test_rtype();
    int n;
    cyc();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0200;
    dec_ready     = 1'b0;
    cyc();
    branch_taken = 1'b0;
    @(negedge clk);
    n = 0;
    while (valid_d !== 1'b1 && n < 8) begin
      cyc();
      @(negedge clk);
      n++;
    end
    checks++;
    if (valid_d !== 1'b1 || PCD !== 32'h200 || InstrD !== 32'h40B5_0533) begin
      errors++;
      $display("FAIL rtype_head: got valid=%b PCD=%h InstrD=%h, want 1 00000200 40b50533",
               valid_d, PCD, InstrD);
    end
    checks++;
    if (Op !== 7'h33 || funct3 !== 3'h0 || funct7 !== 7'h20) begin
      errors++;
      $display("FAIL rtype_fields: got Op=%h f3=%h f7=%h, want 33 0 20", Op, funct3, funct7);
    end
    dec_ready = 1'b1;
  endtask

  task automatic test_pc_wrap();
    cyc();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    dec_ready     = 1'b1;
    cyc();
    branch_taken = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req0: got req=%b addr=%h, want 1 fffffffc", imem_req, imem_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_req1: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (valid_d !== 1'b1 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin
      errors++;
      $display("FAIL wrap_head: got valid=%b PCD=%h PCPlus4D=%h, want 1 fffffffc 00000000",
               valid_d, PCD, PCPlus4D);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    cyc();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0400;
    dec_ready     = 1'b1;
    cyc();
    branch_taken = 1'b0;
    got_pc.delete();
    n = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (valid_d === 1'b1) n++;
      cyc();
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL b2b_rate: got %0d valid cycles, want 20", n);
    end
    checks++;
    if (got_pc.size() != 20 || got_pc[19] !== 32'h0000_044C) begin
      errors++;
      $display("FAIL b2b_last: got %0d deliveries, want 20 ending at 0000044c", got_pc.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch_start();
    test_stall();
    test_redirect();
    test_reset_with_branch();
    test_rtype();
    test_pc_wrap();
    test_back_to_back();
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no completion by 50000, want finished run");
    $fatal(1, "watchdog expired");
  end

endmodule
